// File: rtl/prm_edge_mask_engine_if.sv
// Occupancy-query and edge-result streams of prm_edge_mask_engine.
// The engine takes the slave side; the producer/consumer takes the master side.
interface prm_edge_mask_engine_if #(
  parameter int N_IN   = 15,
  parameter int EDGE_W = 10
);
  logic              occ_valid;
  logic              occ_ready;
  logic [N_IN-1:0]   occ_data;
  logic              res_valid;
  logic              res_ready;
  logic [EDGE_W-1:0] res_edge;
  logic              res_mask;

  modport master (
    output occ_valid, occ_data, res_ready,
    input  occ_ready, res_valid, res_edge, res_mask
  );

  modport slave (
    input  occ_valid, occ_data, res_ready,
    output occ_ready, res_valid, res_edge, res_mask
  );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// Table-driven PRM edge obstacle check: scans loaded care/value terms per query, one mask per edge.
// Optional hit counter output enabled by defining PRM_EDGE_HITCNT_EN.
module prm_edge_mask_engine #(
  parameter int N_IN    = 15,
  parameter int TERM_AW = 10,
  parameter int EDGE_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [TERM_AW-1:0] cfg_addr,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic               cfg_last,
  input  logic               cfg_len_we,
  input  logic [TERM_AW:0]   cfg_len,
  prm_edge_mask_engine_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
`ifdef PRM_EDGE_HITCNT_EN
  ,
  output logic [EDGE_W:0]    hit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int TW = 2 * N_IN + 1;

  state_e              state_q, state_d;
  logic [TERM_AW:0]    len_q, len_d;
  logic [N_IN-1:0]     occ_q, occ_d;
  logic [TERM_AW:0]    fetch_q, fetch_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_final_q, rd_final_d;
  logic                acc_q, acc_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                res_valid_q, res_valid_d;
  logic [EDGE_W-1:0]   res_edge_q, res_edge_d;
  logic                res_mask_q, res_mask_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic [TW-1:0]       term_mem [2**TERM_AW];
  logic [TW-1:0]       mem_rdata;
  logic [N_IN-1:0]     rd_care, rd_val;
  logic                rd_last;
  logic                idle, accept, mem_we, rd_en;
  logic                term_match, close, out_free, stall;
  logic [TERM_AW:0]    len_eff;

  assign idle     = (state_q == IDLE);
  assign accept   = idle & bus.occ_valid;
  assign mem_we   = idle & cfg_we;
  assign len_eff  = (idle & cfg_len_we) ? cfg_len : len_q;

  assign rd_care  = mem_rdata[2*N_IN:N_IN+1];
  assign rd_val   = mem_rdata[N_IN:1];
  assign rd_last  = mem_rdata[0];

  assign term_match = ((occ_q ^ rd_val) & rd_care) == '0;
  assign close      = rd_valid_q & (rd_last | rd_final_q);
  assign out_free   = ~res_valid_q | bus.res_ready;
  // A closing term waits in the read register until the output slot frees up.
  assign stall      = close & ~out_free;
  assign rd_en      = (state_q == RUN) & (fetch_q < len_q) & ~stall;

  // NOTE: the term store and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) term_mem[cfg_addr] <= {cfg_care, cfg_val, cfg_last};
    if (rd_en)  mem_rdata <= term_mem[fetch_q[TERM_AW-1:0]];
  end

  // NOTE: every output of this block gets its default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    len_d       = len_eff;
    occ_d       = occ_q;
    fetch_d     = fetch_q;
    rd_valid_d  = rd_valid_q;
    rd_final_d  = rd_final_q;
    acc_d       = acc_q;
    edge_cnt_d  = edge_cnt_q;
    res_valid_d = res_valid_q & ~bus.res_ready;
    res_edge_d  = res_edge_q;
    res_mask_d  = res_mask_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q | (~idle & (cfg_we | cfg_len_we));

    unique case (state_q)
      IDLE: begin
        if (bus.occ_valid) begin
          occ_d      = bus.occ_data;
          edge_cnt_d = '0;
          acc_d      = 1'b0;
          fetch_d    = '0;
          rd_valid_d = 1'b0;
          if (len_eff == '0) done_d  = 1'b1;
          else               state_d = RUN;
        end
      end

      RUN: begin
        if (rd_en) begin
          fetch_d    = fetch_q + (TERM_AW+1)'(1);
          rd_final_d = (fetch_q == len_q - (TERM_AW+1)'(1));
          rd_valid_d = 1'b1;
        end else if (!stall) begin
          rd_valid_d = 1'b0;
        end

        if (rd_valid_q && !stall) begin
          if (close) begin
            res_valid_d = 1'b1;
            res_edge_d  = edge_cnt_q;
            res_mask_d  = acc_q | term_match;
            acc_d       = 1'b0;
            edge_cnt_d  = edge_cnt_q + EDGE_W'(1);
          end else begin
            acc_d = acc_q | term_match;
          end
          if (rd_final_q) state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      occ_q       <= '0;
      fetch_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_final_q  <= 1'b0;
      acc_q       <= 1'b0;
      edge_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_edge_q  <= '0;
      res_mask_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      occ_q       <= occ_d;
      fetch_q     <= fetch_d;
      rd_valid_q  <= rd_valid_d;
      rd_final_q  <= rd_final_d;
      acc_q       <= acc_d;
      edge_cnt_q  <= edge_cnt_d;
      res_valid_q <= res_valid_d;
      res_edge_q  <= res_edge_d;
      res_mask_q  <= res_mask_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef PRM_EDGE_HITCNT_EN
  logic [EDGE_W:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (accept) begin
      hit_cnt_d = '0;
    end else if (res_valid_q && bus.res_ready && res_mask_q && !(&hit_cnt_q)) begin
      hit_cnt_d = hit_cnt_q + (EDGE_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hit_cnt_q <= '0;
    else     hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

  assign bus.occ_ready = idle;
  assign bus.res_valid = res_valid_q;
  assign bus.res_edge  = res_edge_q;
  assign bus.res_mask  = res_mask_q;
  assign busy          = ~idle;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Directed bench for prm_edge_mask_engine: a term-list model predicts each query's edge results,
// and a negedge compare process checks every valid result, done pulse and stall cycle.
module tb_prm_edge_mask_engine;

  localparam int N_IN    = 15;
  localparam int TERM_AW = 10;
  localparam int EDGE_W  = 10;

  typedef struct {
    int edge_idx;
    bit mask;
  } res_t;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [TERM_AW-1:0] cfg_addr;
  logic [N_IN-1:0]    cfg_care;
  logic [N_IN-1:0]    cfg_val;
  logic               cfg_last;
  logic               cfg_len_we;
  logic [TERM_AW:0]   cfg_len;
  logic               busy;
  logic               done;
  logic               cfg_err;
`ifdef PRM_EDGE_HITCNT_EN
  logic [EDGE_W:0]    hit_cnt;
`endif

  prm_edge_mask_engine_if #(.N_IN(N_IN), .EDGE_W(EDGE_W)) bus ();

  prm_edge_mask_engine #(.N_IN(N_IN), .TERM_AW(TERM_AW), .EDGE_W(EDGE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_care   (cfg_care),
    .cfg_val    (cfg_val),
    .cfg_last   (cfg_last),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
`ifdef PRM_EDGE_HITCNT_EN
    ,
    .hit_cnt    (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the term store as the bench believes it was loaded.
  logic [N_IN-1:0] m_care [2**TERM_AW];
  logic [N_IN-1:0] m_val  [2**TERM_AW];
  bit              m_last [2**TERM_AW];
  int              m_len = 0;

  res_t exp_q[$];
  int   res_cnt   = 0;
  int   done_cnt  = 0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected results: walk the term list, OR matches per edge, close on last flag or final entry.
  task automatic build_expected(input logic [N_IN-1:0] occ);
    bit acc = 0;
    int ec  = 0;
    for (int i = 0; i < m_len; i++) begin
      bit m = (((occ ^ m_val[i]) & m_care[i]) == 0);
      acc = acc | m;
      if (m_last[i] || i == m_len - 1) begin
        exp_q.push_back('{edge_idx: ec, mask: acc});
        acc = 0;
        ec  = (ec + 1) % (2**EDGE_W);
      end
    end
  endtask

  task automatic pin(input string name, input int idx, input int e, input bit mk);
    check({name, "_edge"}, exp_q[idx].edge_idx, e);
    check({name, "_mask"}, 32'(exp_q[idx].mask), 32'(mk));
  endtask

  task automatic cfg_term(input int addr, input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                          input bit last);
    cfg_we   = 1'b1;
    cfg_addr = TERM_AW'(addr);
    cfg_care = care;
    cfg_val  = val;
    cfg_last = last;
    tick();
    cfg_we   = 1'b0;
    m_care[addr] = care;
    m_val[addr]  = val;
    m_last[addr] = last;
  endtask

  task automatic set_len(input int len);
    cfg_len_we = 1'b1;
    cfg_len    = (TERM_AW+1)'(len);
    tick();
    cfg_len_we = 1'b0;
    m_len = len;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_occ_ready"}, bus.occ_ready, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_edge"},  bus.res_edge, 0);
    check({tag, "_res_mask"},  bus.res_mask, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_cfg_err"},   cfg_err, 0);
  endtask

  // Drives one query (expectations already queued). hold: tick at which res_ready rises
  // (0 = high from the start); inj: tick at which a config write is attempted (0 = none);
  // new_len: len written in the same cycle as the query (-1 = none).
  task automatic run_query(input string tag, input logic [N_IN-1:0] occ, input int hold,
                           input int inj, input int new_len, output int lat, output int dlat);
    int n_exp = exp_q.size();
    int rc0   = res_cnt;
    int dc0   = done_cnt;
    bus.res_ready = (hold == 0);
    check({tag, "_occ_ready_before"}, bus.occ_ready, 1);
    bus.occ_valid = 1'b1;
    bus.occ_data  = occ;
    if (new_len >= 0) begin
      cfg_len_we = 1'b1;
      cfg_len    = (TERM_AW+1)'(new_len);
    end
    lat  = -1;
    dlat = -1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 1) begin
        bus.occ_valid = 1'b0;
        cfg_len_we    = 1'b0;
      end
      if (n == hold) bus.res_ready = 1'b1;
      if (inj > 0 && n == inj) begin
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_care = '0;
        cfg_val  = '0;
        cfg_last = 1'b1;
      end
      if (inj > 0 && n == inj + 1) cfg_we = 1'b0;
      if (lat < 0 && bus.res_valid) lat = n;
      if (done) begin
        dlat = n;
        break;
      end
    end
    cfg_we = 1'b0;
    check({tag, "_done_seen"}, 32'(dlat > 0), 1);
    check({tag, "_result_count"}, res_cnt - rc0, n_exp);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
    check({tag, "_occ_ready_after"}, bus.occ_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // Compare process: every cycle a result is presented it must be the model's next result.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", bus.res_edge, 32'hFFFF_FFFF);
        end else begin
          check("res_edge", bus.res_edge, exp_q[0].edge_idx);
          check("res_mask", bus.res_mask, 32'(exp_q[0].mask));
          if (bus.res_ready) begin
            void'(exp_q.pop_front());
            res_cnt++;
          end else begin
            stall_cnt++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_with_results_pending", exp_q.size(), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dlat, s0, d0;
    rst           = 1'b1;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_care      = '0;
    cfg_val       = '0;
    cfg_last      = 1'b0;
    cfg_len_we    = 1'b0;
    cfg_len       = '0;
    bus.occ_valid = 1'b0;
    bus.occ_data  = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Two edges: {t0,t1} and {t2}.
    cfg_term(0, 15'h0003, 15'h0001, 0);
    cfg_term(1, 15'h0004, 15'h0004, 1);
    cfg_term(2, 15'h0000, 15'h0000, 1);
    set_len(3);
    build_expected(15'h0001);
    check("q1_model_count", exp_q.size(), 2);
    pin("q1_r0", 0, 0, 1);
    pin("q1_r1", 1, 1, 1);
    run_query("q1", 15'h0001, 0, 0, -1, lat, dlat);
    check("q1_first_latency", lat, 4);
    build_expected(15'h0002);
    pin("q2_r0", 0, 0, 0);
    pin("q2_r1", 1, 1, 1);
    run_query("q2", 15'h0002, 0, 0, -1, lat, dlat);

    // Empty table: done straight after acceptance, no results.
    set_len(0);
    build_expected(15'h7FFF);
    check("len0_model_count", exp_q.size(), 0);
    run_query("len0", 15'h7FFF, 0, 0, -1, lat, dlat);
    check("len0_done_latency", dlat, 1);

    // len written in the same cycle as the query: new len applies.
    m_len = 1;
    build_expected(15'h0001);
    pin("simul_r0", 0, 0, 1);
    run_query("simul", 15'h0001, 0, 0, 1, lat, dlat);
    check("simul_first_latency", lat, 3);

    // Four single-term edges, results held back for the first 10 post-accept cycles.
    for (int i = 0; i < 4; i++) cfg_term(i, 15'(1 << i), 15'(1 << i), 1);
    set_len(4);
    build_expected(15'h0005);
    pin("bp_r0", 0, 0, 1);
    pin("bp_r1", 1, 1, 0);
    pin("bp_r2", 2, 2, 1);
    pin("bp_r3", 3, 3, 0);
    s0 = stall_cnt;
    run_query("bp", 15'h0005, 11, 0, -1, lat, dlat);
    check("bp_stall_cycles", stall_cnt - s0, 8);

    // Config write during a scan is refused; contents and results unchanged.
    check("cfg_err_clear", cfg_err, 0);
    build_expected(15'h0005);
    run_query("err", 15'h0005, 0, 2, -1, lat, dlat);
    check("cfg_err_set", cfg_err, 1);
    build_expected(15'h0005);
    run_query("rerun", 15'h0005, 0, 0, -1, lat, dlat);
    check("cfg_err_sticky", cfg_err, 1);

    // Final entry without last flag closes an implicit edge; entry 3 lies beyond len.
    cfg_term(0, 15'h0001, 15'h0001, 1);
    cfg_term(1, 15'h0002, 15'h0000, 0);
    cfg_term(2, 15'h0004, 15'h0004, 0);
    cfg_term(3, 15'h0000, 15'h0000, 1);
    set_len(3);
    build_expected(15'h0003);
    check("impl_model_count", exp_q.size(), 2);
    pin("impl_r0", 0, 0, 1);
    pin("impl_r1", 1, 1, 0);
    run_query("impl", 15'h0003, 0, 0, -1, lat, dlat);

    // Reset during a stalled scan.
    build_expected(15'h0003);
    bus.res_ready = 1'b0;
    bus.occ_valid = 1'b1;
    bus.occ_data  = 15'h0003;
    tick();
    bus.occ_valid = 1'b0;
    repeat (3) tick();
    check("mid_busy", busy, 1);
    check("mid_res_valid", bus.res_valid, 1);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst   = 1'b0;
    m_len = 0;
    bus.res_ready = 1'b1;
    d0 = done_cnt;
    repeat (5) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_idle", bus.occ_ready, 1);
    build_expected(15'h0003);
    run_query("post_rst", 15'h0003, 0, 0, -1, lat, dlat);
    check("post_rst_len0_done", dlat, 1);

`ifdef PRM_EDGE_HITCNT_EN
    for (int i = 0; i < 5; i++) cfg_term(i, 15'(1 << i), 15'(1 << i), 1);
    set_len(5);
    build_expected(15'h000D);
    pin("hit_r0", 0, 0, 1);
    pin("hit_r1", 1, 1, 0);
    pin("hit_r2", 2, 2, 1);
    pin("hit_r3", 3, 3, 1);
    pin("hit_r4", 4, 4, 0);
    run_query("hit", 15'h000D, 0, 0, -1, lat, dlat);
    check("hit_cnt", hit_cnt, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
